mem_arb: RTL

MEM_ARB -- requirements
Module: mem_arb

---
 rtl/mem_arb.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/mem_arb.sv
// mem_arb: three-requester arbiter onto one shared memory port.
// Define MEM_ARB_RR_EN for round-robin between i_re and d_re.
module mem_arb #(
    parameter int XLEN      = 32,
    parameter int RR_WEIGHT = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_re,
    input  logic [XLEN-1:0] i_addr,
    output logic            i_ack,
    output logic [XLEN-1:0] i_rdata,
    input  logic            d_re,
    input  logic [XLEN-1:0] d_addr,
    output logic            d_rack,
    output logic [XLEN-1:0] d_rdata,
    input  logic            d_we,
    input  logic [XLEN-1:0] d_waddr,
    input  logic [XLEN-1:0] d_wdata,
    input  logic [3:0]      d_wmask,
    output logic            d_wack,
    output logic            m_re,
    output logic            m_we,
    output logic [XLEN-1:0] m_addr,
    output logic [XLEN-1:0] m_wdata,
    output logic [3:0]      m_wmask,
    input  logic            m_ack,
    input  logic [XLEN-1:0] m_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        GNT_I,
        GNT_DR,
        GNT_DW
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;
    logic [3:0]      wmask_q;
    logic            pick_i;
    logic            pick_dr;
    logic            pick_dw;

`ifdef MEM_ARB_RR_EN
    localparam int CW = (RR_WEIGHT > 1) ? $clog2(RR_WEIGHT) : 1;

    logic          favour_i;
    logic [CW-1:0] rr_cnt;

    // Writes always win; reads alternate according to favour_i.
    always_comb begin
        pick_dw = d_we;
        pick_dr = !d_we && d_re && (!i_re || !favour_i);
        pick_i  = !d_we && i_re && !(d_re && !favour_i);
    end

    // Track who gets the next read contest; data is favoured out of reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            favour_i <= 1'b0;
            rr_cnt   <= '0;
        end else if (state == IDLE) begin
            if (pick_dr) begin
                favour_i <= 1'b1;
                rr_cnt   <= '0;
            end else if (pick_i && d_re) begin
                if (rr_cnt == CW'(RR_WEIGHT - 1)) begin
                    favour_i <= 1'b0;
                    rr_cnt   <= '0;
                end else begin
                    rr_cnt <= rr_cnt + 1'b1;
                end
            end
        end
    end
`else
    // Fixed priority: write, then data read, then instruction read.
    always_comb begin
        pick_dw = d_we;
        pick_dr = !d_we && d_re;
        pick_i  = !d_we && !d_re && i_re;
    end
`endif

    // State register and latch of the winner's payload on leaving IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            wmask_q <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE) begin
                if (pick_dw) begin
                    addr_q  <= d_waddr;
                    wdata_q <= d_wdata;
                    wmask_q <= d_wmask;
                end else if (pick_dr) begin
                    addr_q  <= d_addr;
                    wdata_q <= '0;
                    wmask_q <= '0;
                end else if (pick_i) begin
                    addr_q  <= i_addr;
                    wdata_q <= '0;
                    wmask_q <= '0;
                end
            end
        end
    end

    // Next state and memory/ack outputs; reset silences everything.
    always_comb begin
        state_nx = state;
        m_re     = 1'b0;
        m_we     = 1'b0;
        m_addr   = '0;
        m_wdata  = '0;
        m_wmask  = '0;
        i_ack    = 1'b0;
        i_rdata  = '0;
        d_rack   = 1'b0;
        d_rdata  = '0;
        d_wack   = 1'b0;
        unique case (state)
            IDLE: begin
                if (pick_dw) state_nx = GNT_DW;
                else if (pick_dr) state_nx = GNT_DR;
                else if (pick_i) state_nx = GNT_I;
            end
            GNT_I: begin
                m_re  = !reset;
                i_ack = m_ack && !reset;
                if (!reset) m_addr = addr_q;
                if (i_ack) i_rdata = m_rdata;
                if (m_ack) state_nx = IDLE;
            end
            GNT_DR: begin
                m_re   = !reset;
                d_rack = m_ack && !reset;
                if (!reset) m_addr = addr_q;
                if (d_rack) d_rdata = m_rdata;
                if (m_ack) state_nx = IDLE;
            end
            GNT_DW: begin
                m_we   = !reset;
                d_wack = m_ack && !reset;
                if (!reset) begin
                    m_addr  = addr_q;
                    m_wdata = wdata_q;
                    m_wmask = wmask_q;
                end
                if (m_ack) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule
